// File: rtl/dma_arb_pkg.sv
// Shared types for the DMA arbiter: FSM states, requester indices and the
// descriptor encodings agreed with the DMA engine.
package dma_arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    BUSY  = 2'd2,
    DONE  = 2'd3
  } arb_state_e;

  localparam int unsigned REQ_INPUT  = 0;
  localparam int unsigned REQ_WEIGHT = 1;
  localparam int unsigned REQ_OUTPUT = 2;

  typedef enum logic {
    SRAM_INPUT  = 1'b0,
    SRAM_WEIGHT = 1'b1
  } sram_type_e;

  typedef enum logic {
    DMA_READ  = 1'b0,
    DMA_WRITE = 1'b1
  } dma_type_e;

endpackage

// File: rtl/dma_arbiter_if.sv
// Requester-side and DMA-side signal bundle of the DMA arbiter.
// The arbiter is the slave; requesters plus DMA engine form the master side.
interface dma_arbiter_if #(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned DRAM_AW = 32,
  parameter int unsigned LOC_AW  = 18,
  parameter int unsigned ID_W    = 2
);
  logic [N_REQ-1:0]         req;
  logic [N_REQ-1:0]         urgent;
  logic [N_REQ*DRAM_AW-1:0] req_dram_start;
  logic [N_REQ*DRAM_AW-1:0] req_dram_end;
  logic [N_REQ*LOC_AW-1:0]  req_loc_start;
  logic [N_REQ*LOC_AW-1:0]  req_loc_end;
  logic [N_REQ-1:0]         req_sram_type;
  logic [N_REQ-1:0]         req_dma_type;
  logic [N_REQ-1:0]         req_buf_select;
  logic [N_REQ-1:0]         req_done;
  logic [DRAM_AW-1:0]       dma_dram_start;
  logic [DRAM_AW-1:0]       dma_dram_end;
  logic [LOC_AW-1:0]        dma_loc_start;
  logic [LOC_AW-1:0]        dma_loc_end;
  logic                     dma_sram_type;
  logic                     dma_type;
  logic                     dma_buf_select;
  logic                     dma_start;
  logic                     dma_done;
  logic                     busy;
  logic [ID_W-1:0]          grant_id;
  logic                     err_spurious;

  modport master (
    output req, urgent, req_dram_start, req_dram_end, req_loc_start,
           req_loc_end, req_sram_type, req_dma_type, req_buf_select, dma_done,
    input  req_done, dma_dram_start, dma_dram_end, dma_loc_start, dma_loc_end,
           dma_sram_type, dma_type, dma_buf_select, dma_start, busy, grant_id,
           err_spurious
  );

  modport slave (
    input  req, urgent, req_dram_start, req_dram_end, req_loc_start,
           req_loc_end, req_sram_type, req_dma_type, req_buf_select, dma_done,
    output req_done, dma_dram_start, dma_dram_end, dma_loc_start, dma_loc_end,
           dma_sram_type, dma_type, dma_buf_select, dma_start, busy, grant_id,
           err_spurious
  );
endinterface

// File: rtl/dma_arbiter_rr_pick.sv
// Combinational winner finder: lowest-index urgent requester, otherwise the
// first requester at or after rr_ptr, wrapping modulo N.
module rr_pick #(
  parameter int unsigned N  = 3,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  eff,
  input  logic [N-1:0]  urgent,
  input  logic [IW-1:0] rr_ptr,
  output logic          valid,
  output logic [IW-1:0] idx
);

  logic [N-1:0] urg_eff;
  logic         found;
  int unsigned  pos;

  assign urg_eff = eff & urgent;
  assign valid   = |eff;

  always_comb begin
    idx   = '0;
    found = 1'b0;
    pos   = 0;
    if (|urg_eff) begin
      for (int unsigned i = 0; i < N; i++) begin
        if (!found && urg_eff[i]) begin
          idx   = IW'(i);
          found = 1'b1;
        end
      end
    end else begin
      // Explicit wrap keeps the search correct when N is not a power of two.
      for (int unsigned k = 0; k < N; k++) begin
        pos = 32'(rr_ptr) + k;
        if (pos >= N) pos = pos - N;
        if (!found && eff[pos]) begin
          idx   = IW'(pos);
          found = 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/dma_arbiter.sv
// Shares one DMA engine between N_REQ requesters: round-robin with urgent
// override, descriptor latch, DMA start/done handshake and done pulse.
module dma_arbiter
  import dma_arb_pkg::*;
#(
  parameter int unsigned N_REQ   = 3,
  parameter int unsigned DRAM_AW = 32,
  parameter int unsigned LOC_AW  = 18,
  parameter int unsigned ID_W    = 2
) (
  input logic          clk,
  input logic          rst,
  dma_arbiter_if.slave bus
);

  arb_state_e         state, state_nx;
  logic [ID_W-1:0]    rr_ptr;
  logic [N_REQ-1:0]   last_mask;
  logic [ID_W-1:0]    grant_q;
  logic [N_REQ-1:0]   grant_onehot;
  logic [N_REQ-1:0]   eff;
  logic               pick_valid;
  logic [ID_W-1:0]    pick_idx;
  logic [DRAM_AW-1:0] dram_start_q;
  logic [DRAM_AW-1:0] dram_end_q;
  logic [LOC_AW-1:0]  loc_start_q;
  logic [LOC_AW-1:0]  loc_end_q;
  sram_type_e         sram_type_q;
  dma_type_e          dma_type_q;
  logic               buf_select_q;
  logic               err_q;

  assign eff          = bus.req & ~last_mask;
  assign grant_onehot = N_REQ'(1) << grant_q;

  rr_pick #(
    .N  (N_REQ),
    .IW (ID_W)
  ) u_pick (
    .eff    (eff),
    .urgent (bus.urgent),
    .rr_ptr (rr_ptr),
    .valid  (pick_valid),
    .idx    (pick_idx)
  );

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (pick_valid) state_nx = ISSUE;
      ISSUE:   state_nx = BUSY;
      BUSY:    if (bus.dma_done) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr       <= '0;
      last_mask    <= '0;
      grant_q      <= '0;
      dram_start_q <= '0;
      dram_end_q   <= '0;
      loc_start_q  <= '0;
      loc_end_q    <= '0;
      sram_type_q  <= SRAM_INPUT;
      dma_type_q   <= DMA_READ;
      buf_select_q <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          // The mask from the previous DONE only shields this one IDLE cycle.
          last_mask <= '0;
          if (pick_valid) begin
            grant_q      <= pick_idx;
            dram_start_q <= bus.req_dram_start[int'(pick_idx)*DRAM_AW +: DRAM_AW];
            dram_end_q   <= bus.req_dram_end[int'(pick_idx)*DRAM_AW +: DRAM_AW];
            loc_start_q  <= bus.req_loc_start[int'(pick_idx)*LOC_AW +: LOC_AW];
            loc_end_q    <= bus.req_loc_end[int'(pick_idx)*LOC_AW +: LOC_AW];
            sram_type_q  <= sram_type_e'(bus.req_sram_type[pick_idx]);
            dma_type_q   <= dma_type_e'(bus.req_dma_type[pick_idx]);
            buf_select_q <= bus.req_buf_select[pick_idx];
          end
        end
        DONE: begin
          rr_ptr    <= (grant_q == ID_W'(N_REQ - 1)) ? '0 : grant_q + 1'b1;
          last_mask <= grant_onehot;
        end
        default: ;
      endcase
      if (bus.dma_done && state != BUSY) err_q <= 1'b1;
    end
  end

  assign bus.busy           = (state != IDLE);
  assign bus.dma_start      = (state == BUSY);
  assign bus.req_done       = (state == DONE) ? grant_onehot : '0;
  assign bus.grant_id       = grant_q;
  assign bus.dma_dram_start = dram_start_q;
  assign bus.dma_dram_end   = dram_end_q;
  assign bus.dma_loc_start  = loc_start_q;
  assign bus.dma_loc_end    = loc_end_q;
  assign bus.dma_sram_type  = sram_type_q;
  assign bus.dma_type       = dma_type_q;
  assign bus.dma_buf_select = buf_select_q;
  assign bus.err_spurious   = err_q;

endmodule

// File: tb/tb_dma_arbiter.sv
// Self-checking bench for dma_arbiter: directed scenarios plus a randomized
// request stream compared against a transaction-level arbitration model.
module tb_dma_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  dma_arbiter_if bus ();

  dma_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int m_rr     = 0;

  logic [31:0] d_ds [3];
  logic [31:0] d_de [3];
  logic [17:0] d_ls [3];
  logic [17:0] d_le [3];
  logic        d_st [3];
  logic        d_dt [3];
  logic        d_bs [3];

  // Winner = lowest-index urgent requester, else nearest ring distance from ptr.
  function automatic int model_pick(input logic [2:0] r, input logic [2:0] u, input int ptr);
    int best  = -1;
    int bestd = 99;
    if ((r & u) != 3'b000) begin
      for (int i = 0; i < 3; i++) if (r[i] && u[i] && best < 0) best = i;
      return best;
    end
    for (int i = 0; i < 3; i++) begin
      if (r[i] && ((i - ptr + 3) % 3) < bestd) begin
        bestd = (i - ptr + 3) % 3;
        best  = i;
      end
    end
    return best;
  endfunction

  function automatic logic [102:0] desc_of(input int i);
    return {d_ds[i], d_de[i], d_ls[i], d_le[i], d_st[i], d_dt[i], d_bs[i]};
  endfunction

  function automatic logic [102:0] dut_desc();
    return {bus.dma_dram_start, bus.dma_dram_end, bus.dma_loc_start, bus.dma_loc_end,
            bus.dma_sram_type, bus.dma_type, bus.dma_buf_select};
  endfunction

  task automatic rand_desc(input int i);
    d_ds[i] = $urandom;
    d_de[i] = $urandom;
    d_ls[i] = 18'($urandom);
    d_le[i] = 18'($urandom);
    d_st[i] = 1'($urandom);
    d_dt[i] = 1'($urandom);
    d_bs[i] = 1'($urandom);
  endtask

  task automatic drive_desc();
    for (int i = 0; i < 3; i++) begin
      bus.req_dram_start[i*32 +: 32] = d_ds[i];
      bus.req_dram_end[i*32 +: 32]   = d_de[i];
      bus.req_loc_start[i*18 +: 18]  = d_ls[i];
      bus.req_loc_end[i*18 +: 18]    = d_le[i];
      bus.req_sram_type[i]           = d_st[i];
      bus.req_dma_type[i]            = d_dt[i];
      bus.req_buf_select[i]          = d_bs[i];
    end
  endtask

  task automatic do_reset();
    rst = 1'b0;
    bus.req = '0;
    bus.urgent = '0;
    bus.dma_done = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_rr = 0;
  endtask

  task automatic wait_start(output int cyc, output bit ok);
    ok = 1'b0;
    cyc = 0;
    for (int n = 0; n < 40 && !ok; n++) begin
      @(negedge clk);
      cyc++;
      if (bus.dma_start === 1'b1) ok = 1'b1;
    end
  endtask

  // Waits lat cycles in BUSY, pulses dma_done, returns req_done seen in DONE.
  task automatic pulse_done(input int lat, output logic [2:0] seen);
    repeat (lat) @(negedge clk);
    bus.dma_done = 1'b1;
    @(negedge clk);
    bus.dma_done = 1'b0;
    seen = bus.req_done;
  endtask

  task automatic test_reset();
    do_reset();
    n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%0b exp=0", bus.busy); end
    n_checks++; if (bus.dma_start !== 1'b0) begin n_fail++; $display("FAIL reset_dma_start got=%0b exp=0", bus.dma_start); end
    n_checks++; if (bus.req_done !== 3'b000) begin n_fail++; $display("FAIL reset_req_done got=%0b exp=000", bus.req_done); end
    n_checks++; if (bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL reset_grant_id got=%0d exp=0", bus.grant_id); end
    n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL reset_err got=%0b exp=0", bus.err_spurious); end
    n_checks++; if (dut_desc() !== 103'd0) begin n_fail++; $display("FAIL reset_desc got=%0h exp=0", dut_desc()); end
  endtask

  task automatic test_single();
    logic [2:0] seen;
    d_ds[0] = 32'h0020_0000; d_de[0] = 32'h0020_0044;
    d_ls[0] = 18'd0; d_le[0] = 18'd17;
    d_st[0] = 1'b0; d_dt[0] = 1'b0; d_bs[0] = 1'b0;
    drive_desc();
    bus.req = 3'b001;
    @(negedge clk);
    n_checks++; if (bus.dma_start !== 1'b0 || bus.busy !== 1'b1) begin n_fail++; $display("FAIL single_issue start=%0b busy=%0b exp start=0 busy=1", bus.dma_start, bus.busy); end
    @(negedge clk);
    n_checks++; if (bus.dma_start !== 1'b1) begin n_fail++; $display("FAIL single_start_latency got=%0b exp=1", bus.dma_start); end
    n_checks++; if (dut_desc() !== desc_of(0)) begin n_fail++; $display("FAIL single_desc got=%0h exp=%0h", dut_desc(), desc_of(0)); end
    pulse_done(19, seen);
    n_checks++; if (seen !== 3'b001) begin n_fail++; $display("FAIL single_req_done got=%0b exp=001", seen); end
    n_checks++; if (bus.dma_start !== 1'b0) begin n_fail++; $display("FAIL single_start_fall got=%0b exp=0", bus.dma_start); end
    bus.req = 3'b000;
    @(negedge clk);
    n_checks++; if (bus.busy !== 1'b0 || bus.req_done !== 3'b000) begin n_fail++; $display("FAIL single_idle busy=%0b done=%0b exp 0/000", bus.busy, bus.req_done); end
    m_rr = 1;
  endtask

  task automatic test_round_robin();
    logic [2:0] pend, seen;
    int exp, cyc;
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) rand_desc(i);
    drive_desc();
    for (int round = 0; round < 2; round++) begin
      pend = 3'b111;
      bus.req = pend;
      for (int k = 0; k < 3; k++) begin
        exp = model_pick(pend, 3'b000, m_rr);
        wait_start(cyc, ok);
        n_checks++; if (!ok || cyc != ((k == 0) ? 2 : 3)) begin n_fail++; $display("FAIL rr_start_timing got=%0d exp=%0d", cyc, (k == 0) ? 2 : 3); end
        n_checks++; if (bus.grant_id !== 2'(exp)) begin n_fail++; $display("FAIL rr_grant got=%0d exp=%0d", bus.grant_id, exp); end
        n_checks++; if (dut_desc() !== desc_of(exp)) begin n_fail++; $display("FAIL rr_desc got=%0h exp=%0h", dut_desc(), desc_of(exp)); end
        pulse_done(int'($urandom_range(1, 6)), seen);
        n_checks++; if (seen !== (3'b001 << exp)) begin n_fail++; $display("FAIL rr_req_done got=%0b exp=%0b", seen, 3'b001 << exp); end
        pend &= ~(3'b001 << exp);
        bus.req = pend;
        m_rr = (exp + 1) % 3;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_urgent();
    logic [2:0] pend, seen;
    int exp, cyc;
    bit ok;
    do_reset();
    for (int i = 0; i < 3; i++) rand_desc(i);
    drive_desc();
    bus.req = 3'b001;
    wait_start(cyc, ok);
    pulse_done(2, seen);
    bus.req = 3'b000;
    m_rr = 1;
    @(negedge clk);
    pend = 3'b111;
    bus.req = pend;
    bus.urgent = 3'b100;
    for (int k = 0; k < 3; k++) begin
      exp = model_pick(pend, bus.urgent, m_rr);
      wait_start(cyc, ok);
      n_checks++; if (!ok || bus.grant_id !== 2'(exp)) begin n_fail++; $display("FAIL urgent_grant got=%0d exp=%0d", bus.grant_id, exp); end
      pulse_done(int'($urandom_range(1, 5)), seen);
      n_checks++; if (seen !== (3'b001 << exp)) begin n_fail++; $display("FAIL urgent_req_done got=%0b exp=%0b", seen, 3'b001 << exp); end
      pend &= ~(3'b001 << exp);
      bus.req = pend;
      m_rr = (exp + 1) % 3;
    end
    bus.urgent = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_stale();
    logic [2:0] seen;
    int cyc;
    bit ok;
    for (int variant = 0; variant < 2; variant++) begin
      bus.req = 3'b001;
      wait_start(cyc, ok);
      n_checks++; if (!ok) begin n_fail++; $display("FAIL stale_first_grant got=no_start exp=start"); end
      pulse_done(3, seen);
      n_checks++; if (seen !== 3'b001) begin n_fail++; $display("FAIL stale_req_done got=%0b exp=001", seen); end
      @(negedge clk);
      @(negedge clk);
      n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stale_masked got busy=%0b exp=0", bus.busy); end
      if (variant == 0) begin
        bus.req = 3'b000;
        for (int n = 0; n < 3; n++) begin
          @(negedge clk);
          n_checks++; if (bus.busy !== 1'b0) begin n_fail++; $display("FAIL stale_no_regrant got busy=%0b exp=0", bus.busy); end
        end
      end else begin
        @(negedge clk);
        n_checks++; if (bus.busy !== 1'b1 || bus.grant_id !== 2'd0) begin n_fail++; $display("FAIL stale_regrant busy=%0b id=%0d exp 1/0", bus.busy, bus.grant_id); end
        wait_start(cyc, ok);
        pulse_done(2, seen);
        bus.req = 3'b000;
        @(negedge clk);
      end
    end
    m_rr = 1;
  endtask

  task automatic test_spurious();
    logic [2:0] seen;
    int cyc;
    bit ok;
    @(negedge clk);
    bus.dma_done = 1'b1;
    @(negedge clk);
    bus.dma_done = 1'b0;
    n_checks++; if (bus.err_spurious !== 1'b1) begin n_fail++; $display("FAIL spur_idle_err got=%0b exp=1", bus.err_spurious); end
    n_checks++; if (bus.busy !== 1'b0 || bus.req_done !== 3'b000) begin n_fail++; $display("FAIL spur_idle_state busy=%0b done=%0b exp 0/000", bus.busy, bus.req_done); end
    do_reset();
    n_checks++; if (bus.err_spurious !== 1'b0) begin n_fail++; $display("FAIL spur_reset_clear got=%0b exp=0", bus.err_spurious); end
    bus.req = 3'b010;
    @(negedge clk);
    bus.dma_done = 1'b1;
    @(negedge clk);
    bus.dma_done = 1'b0;
    n_checks++; if (bus.err_spurious !== 1'b1 || bus.dma_start !== 1'b1) begin n_fail++; $display("FAIL spur_issue err=%0b start=%0b exp 1/1", bus.err_spurious, bus.dma_start); end
    pulse_done(4, seen);
    n_checks++; if (seen !== 3'b010) begin n_fail++; $display("FAIL spur_issue_done got=%0b exp=010", seen); end
    bus.req = 3'b000;
    m_rr = 2;
    wait_start(cyc, ok);
    n_checks++; if (ok) begin n_fail++; $display("FAIL spur_no_extra_grant got=start exp=none"); end
  endtask

  task automatic test_midreset();
    logic [2:0] seen;
    int exp, cyc;
    bit ok;
    do_reset();
    rand_desc(2);
    drive_desc();
    bus.req = 3'b100;
    wait_start(cyc, ok);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    n_checks++; if (bus.dma_start !== 1'b0 || bus.busy !== 1'b0 || bus.req_done !== 3'b000) begin n_fail++; $display("FAIL midreset_async start=%0b busy=%0b done=%0b exp 0/0/000", bus.dma_start, bus.busy, bus.req_done); end
    @(negedge clk);
    rst = 1'b1;
    m_rr = 0;
    exp = model_pick(bus.req, bus.urgent, m_rr);
    wait_start(cyc, ok);
    n_checks++; if (!ok || cyc != 2 || bus.grant_id !== 2'(exp)) begin n_fail++; $display("FAIL midreset_regrant cyc=%0d id=%0d exp cyc=2 id=%0d", cyc, bus.grant_id, exp); end
    n_checks++; if (dut_desc() !== desc_of(exp)) begin n_fail++; $display("FAIL midreset_desc got=%0h exp=%0h", dut_desc(), desc_of(exp)); end
    pulse_done(2, seen);
    n_checks++; if (seen !== (3'b001 << exp)) begin n_fail++; $display("FAIL midreset_done got=%0b exp=%0b", seen, 3'b001 << exp); end
    bus.req = 3'b000;
    m_rr = (exp + 1) % 3;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [2:0] pend, add, seen, oh;
    logic [102:0] saved;
    int exp, cyc;
    bit ok, fresh;
    do_reset();
    pend = 3'b000;
    fresh = 1'b1;
    for (int it = 0; it < 40; it++) begin
      if (pend == 3'b000) begin
        pend = 3'($urandom_range(1, 7));
        for (int i = 0; i < 3; i++) if (pend[i]) rand_desc(i);
        drive_desc();
        bus.urgent = 3'($urandom);
        bus.req = pend;
        fresh = 1'b1;
      end
      exp = model_pick(pend, bus.urgent, m_rr);
      oh = 3'b001 << exp;
      wait_start(cyc, ok);
      n_checks++; if (!ok || cyc != (fresh ? 2 : 3)) begin n_fail++; $display("FAIL rand_timing it=%0d got=%0d exp=%0d", it, cyc, fresh ? 2 : 3); end
      n_checks++; if (bus.grant_id !== 2'(exp)) begin n_fail++; $display("FAIL rand_grant it=%0d got=%0d exp=%0d", it, bus.grant_id, exp); end
      n_checks++; if (dut_desc() !== desc_of(exp)) begin n_fail++; $display("FAIL rand_desc it=%0d got=%0h exp=%0h", it, dut_desc(), desc_of(exp)); end
      saved = desc_of(exp);
      add = 3'($urandom) & ~pend;
      pend |= add;
      for (int i = 0; i < 3; i++) if (add[i] || i == exp) rand_desc(i);
      drive_desc();
      bus.urgent = 3'($urandom);
      bus.req = pend;
      pulse_done(int'($urandom_range(1, 8)), seen);
      n_checks++; if (seen !== oh) begin n_fail++; $display("FAIL rand_req_done it=%0d got=%0b exp=%0b", it, seen, oh); end
      n_checks++; if (dut_desc() !== saved) begin n_fail++; $display("FAIL rand_frozen it=%0d got=%0h exp=%0h", it, dut_desc(), saved); end
      pend &= ~oh;
      add = 3'($urandom) & ~pend & ~oh;
      pend |= add;
      for (int i = 0; i < 3; i++) if (add[i]) rand_desc(i);
      drive_desc();
      bus.urgent = 3'($urandom);
      bus.req = pend;
      m_rr = (exp + 1) % 3;
      fresh = 1'b0;
      if (pend == 3'b000) @(negedge clk);
    end
    bus.req = 3'b000;
    bus.urgent = 3'b000;
  endtask

  initial begin
    bus.req = '0;
    bus.urgent = '0;
    bus.dma_done = 1'b0;
    for (int i = 0; i < 3; i++) rand_desc(i);
    drive_desc();
    test_reset();
    test_single();
    test_round_robin();
    test_urgent();
    test_stale();
    test_spurious();
    test_midreset();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
